hps_cmd_assembler: RTL and testbench
====================================

Name: hps_cmd_assembler

Overview:
- Sits directly downstream of the HPS-to-FPGA Avalon write export.
- Consumes 32-bit words written by the HPS and frames them into commands: one header word, then N payload words.
- Validates the header and buffers the payload.
- Presents a complete command to the core logic over a valid/ready handshake.

Parameters:
- MAX_WORDS, 8, maximum payload words per command; legal range 1..15.
- TIMEOUT, 1024, idle cycles allowed between payload words before the frame is aborted; 0 disables the timeout.
- MAGIC, 8'hA5, required value of header bits [31:24].

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- write  in  1  word strobe from the HPS write export, one word per cycle high
- writedata  in  32  word from the HPS write export
- cmd_valid  out  1  complete command available
- cmd_ready  in  1  consumer accepts the command
- cmd_opcode  out  4  header bits [23:20]
- cmd_len  out  4  payload word count
- cmd_payload  out  MAX_WORDS*32  word k occupies bits [32k+31:32k]; unused words are zero
- busy  out  1  high in COLLECT or ISSUE
- err_pulse  out  1  one-cycle pulse when a frame is rejected
- err_code  out  2  1 = bad magic, 2 = bad length, 3 = timeout; held until the next error
- ovf_pulse  out  1  one-cycle pulse when a word is dropped

Behaviour:
- Clock and reset: one clock, clock. reset_n is asynchronous, active-low.
- Reset state: IDLE. All outputs 0, payload buffer 0, word and timeout counters 0.
- Header word layout: [31:24] magic, [23:20] opcode, [19:4] ignored, [3:0] len.
- IDLE:
  - On write, evaluate the header.
  - If magic != MAGIC: err_pulse next cycle, err_code = 1, stay IDLE.
  - Else if len == 0 or len > MAX_WORDS: err_pulse next cycle, err_code = 2, stay IDLE.
  - Else: latch opcode and len, clear the payload buffer, word index = 0, go to COLLECT.
- COLLECT:
  - Each write stores writedata at the current index, increments the index and clears the timeout counter.
  - When the index reaches len, go to ISSUE.
  - cmd_valid rises on the clock edge after the final payload write, i.e. 1 cycle of latency.
  - Timeout counter increments on every non-write cycle. When it reaches TIMEOUT (TIMEOUT != 0): err_pulse, err_code = 3, buffer discarded, back to IDLE.
- ISSUE:
  - cmd_valid stays high; opcode, len and payload are stable until the handshake.
  - On cmd_valid && cmd_ready: cmd_valid drops the next cycle, go to IDLE.
  - No timeout applies in ISSUE.
- Write arriving during ISSUE: dropped, ovf_pulse. This holds even in the handshake cycle. The first accepted header is the one written in the cycle after cmd_valid falls.
- Pulse widths: err_pulse and ovf_pulse are exactly one cycle per event. A bad header written back-to-back gives consecutive pulses.
- Reset mid-operation: immediate return to the reset state; any partial or pending command is lost and no pulse is emitted.
- Consumer stall: cmd_ready may be held low indefinitely without any change to the outputs.
- Width rules:
  - Word index is 4 bits.
  - Timeout counter is wide enough to hold TIMEOUT and saturates at it.
  - len is compared unsigned.

Decomposition:
- Shared package hps_cmd_pkg holds:
  - state enum {IDLE, COLLECT, ISSUE};
  - err_code constants ERR_MAGIC = 1, ERR_LEN = 2, ERR_TIMEOUT = 3;
  - header field bit positions and the default MAGIC.
- One sub-module, cmd_timeout_cnt: a saturating counter with clear and enable, plus an expired flag.
- The FSM and payload buffer stay in the top level.

Test Plan:
- Frame accepted: header 32'hA530_0002, payload 32'h1111_1111 then 32'h2222_2222, cmd_ready = 1 → cmd_valid 1 cycle after the second word; opcode = 3, len = 2, payload[63:0] = 64'h2222_2222_1111_1111, upper words 0; valid for 1 cycle.
- Bad headers: 32'h5A30_0001 → err_pulse, err_code = 1, stays IDLE. 32'hA530_0000 and 32'hA530_0009 (MAX_WORDS = 8) → err_code = 2 for each, busy stays 0.
- Timeout: valid header len = 3, one payload word, then no writes; TIMEOUT = 16 → err_pulse 16 cycles after the last write, err_code = 3. A following valid frame is accepted normally.
- Stall and overflow: hold cmd_ready = 0 for 20 cycles after cmd_valid and write 2 words during ISSUE → two ovf_pulse; outputs unchanged. Then raise cmd_ready → single handshake, return to IDLE.
- Reset mid-frame: assert reset_n = 0 after 1 of 4 payload words → outputs 0 asynchronously. After release, a len = 1 frame completes with the correct payload and no leftover data.
- Handshake collision: write a header in the same cycle as cmd_valid && cmd_ready → ovf_pulse, then IDLE. The header rewritten the next cycle is accepted.

Source files
------------

// File: rtl/hps_cmd_pkg.sv
// Shared definitions for the HPS command assembler.
//   - state_e      : assembler FSM states
//   - ERR_*        : err_code values reported on a rejected frame
//   - HDR_*_LSB    : bit positions of the header fields
//   - DEFAULT_MAGIC: header tag expected in bits [31:24]
package hps_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MAGIC   = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Header layout: [31:24] magic, [23:20] opcode, [19:4] unused, [3:0] len
    localparam int unsigned HDR_MAGIC_LSB = 24;
    localparam int unsigned HDR_OPC_LSB   = 20;
    localparam int unsigned HDR_LEN_LSB   = 0;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/hps_cmd_assembler_if.sv
// Bus bundle between the HPS write export / core logic and the assembler.
//   write, writedata : one 32-bit word per cycle with write high
//   cmd_valid/ready  : command handshake towards the core logic
//   cmd_opcode/len   : decoded header fields of the presented command
//   cmd_payload      : word k in bits [32k+31:32k], unused words zero
// master = HPS/consumer side, slave = assembler.
interface hps_cmd_assembler_if #(
    parameter int unsigned MAX_WORDS = 8
) ();

    logic                      write;
    logic [31:0]               writedata;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [3:0]                cmd_opcode;
    logic [3:0]                cmd_len;
    logic [MAX_WORDS*32-1:0]   cmd_payload;

    modport master (
        output write, writedata, cmd_ready,
        input  cmd_valid, cmd_opcode, cmd_len, cmd_payload
    );

    modport slave (
        input  write, writedata, cmd_ready,
        output cmd_valid, cmd_opcode, cmd_len, cmd_payload
    );

endinterface

// File: rtl/cmd_timeout_cnt.sv
// Saturating idle-cycle counter used to abort stalled frames.
//   clock, reset_n : clock and asynchronous active-low reset
//   clr            : zero the counter (has priority over en)
//   en             : count one idle cycle
//   expired        : the count reaches LIMIT on this edge (or already sits there)
// LIMIT = 0 disables the counter; expired then never asserts.
module cmd_timeout_cnt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CNT_W   = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (LIMIT != 0)) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Flag on the edge that reaches the limit so the abort lands
            // exactly LIMIT idle cycles after the last write.
            expired = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hps_cmd_assembler.sv
// Frames 32-bit HPS writes into commands (header + N payload words) and
// presents each complete command over a valid/ready handshake.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : write/writedata in, cmd_valid/opcode/len/payload out, cmd_ready in
//   busy           : high while collecting payload or presenting a command
//   err_pulse      : one-cycle pulse per rejected frame
//   err_code       : cause of the last rejection (magic/length/timeout), held
//   ovf_pulse      : one-cycle pulse per word dropped while a command is pending
module hps_cmd_assembler
    import hps_cmd_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [7:0]  MAGIC     = DEFAULT_MAGIC
) (
    input  logic                 clock,
    input  logic                 reset_n,
    hps_cmd_assembler_if.slave   bus,
    output logic                 busy,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic                 ovf_pulse
);

    state_e      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] payload_q [MAX_WORDS];
    logic [31:0] payload_d [MAX_WORDS];
    logic        err_pulse_q, err_pulse_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        ovf_pulse_q, ovf_pulse_d;

    logic [7:0]  hdr_magic;
    logic [3:0]  hdr_opcode;
    logic [3:0]  hdr_len;

    logic        tmo_clr, tmo_en, tmo_expired;

    assign hdr_magic  = bus.writedata[HDR_MAGIC_LSB +: 8];
    assign hdr_opcode = bus.writedata[HDR_OPC_LSB +: 4];
    assign hdr_len    = bus.writedata[HDR_LEN_LSB +: 4];

    // Counter only runs across idle cycles inside COLLECT.
    assign tmo_clr = (state_q != COLLECT) || bus.write;
    assign tmo_en  = (state_q == COLLECT) && !bus.write;

    cmd_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_d       = len_q;
        idx_d       = idx_q;
        payload_d   = payload_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        ovf_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.write) begin
                    if (hdr_magic != MAGIC) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_MAGIC;
                    end else if ((hdr_len == 4'd0) || (32'(hdr_len) > MAX_WORDS)) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        opcode_d = hdr_opcode;
                        len_d    = hdr_len;
                        idx_d    = '0;
                        for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                            payload_d[i] = '0;
                        end
                        state_d  = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (bus.write) begin
                    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                        if (idx_q == 4'(i)) begin
                            payload_d[i] = bus.writedata;
                        end
                    end
                    idx_d = idx_q + 4'd1;
                    if ((idx_q + 4'd1) == len_q) begin
                        state_d = ISSUE;
                    end
                end else if (tmo_expired) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    idx_d       = '0;
                    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                        payload_d[i] = '0;
                    end
                    state_d     = IDLE;
                end
            end

            ISSUE: begin
                // Writes are dropped for the whole ISSUE state, handshake cycle included.
                if (bus.write) begin
                    ovf_pulse_d = 1'b1;
                end
                if (bus.cmd_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            ovf_pulse_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                payload_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            ovf_pulse_q <= ovf_pulse_d;
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                payload_q[i] <= payload_d[i];
            end
        end
    end

    for (genvar g = 0; g < MAX_WORDS; g++) begin : g_payload
        assign bus.cmd_payload[32*g +: 32] = payload_q[g];
    end

    assign bus.cmd_valid  = (state_q == ISSUE);
    assign bus.cmd_opcode = opcode_q;
    assign bus.cmd_len    = len_q;
    assign busy           = (state_q != IDLE);
    assign err_pulse      = err_pulse_q;
    assign err_code       = err_code_q;
    assign ovf_pulse      = ovf_pulse_q;

endmodule

// File: tb/tb_hps_cmd_assembler.sv
// Self-checking bench for hps_cmd_assembler: directed scenarios followed by
// randomized traffic, every cycle compared against a frame-level reference model.
module tb_hps_cmd_assembler;

    localparam int unsigned MAXW = 8;
    localparam int unsigned TMO  = 16;
    localparam int unsigned PW   = MAXW * 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       ovf_pulse;

    hps_cmd_assembler_if #(.MAX_WORDS(MAXW)) bus ();

    hps_cmd_assembler #(
        .MAX_WORDS (MAXW),
        .TIMEOUT   (TMO),
        .MAGIC     (8'hA5)
    ) dut (
        .clock     (clk),
        .reset_n   (rst_n),
        .bus       (bus),
        .busy      (busy),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .ovf_pulse (ovf_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is "need" words long; words gathered so far sit
    // in a queue; a finished frame is pending until the consumer takes it.
    bit          m_pending;
    int          m_need;
    int          m_idle;
    logic [31:0] m_words[$];
    logic [3:0]  m_opc;
    logic [3:0]  m_len;
    logic [1:0]  m_code;
    bit          m_err;
    bit          m_ovf;

    task automatic check_eq(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0;
        m_need    = 0;
        m_idle    = 0;
        m_words.delete();
        m_opc     = '0;
        m_len     = '0;
        m_code    = '0;
        m_err     = 0;
        m_ovf     = 0;
    endtask

    task automatic model_step(input logic w, input logic [31:0] d, input logic r);
        int len;
        m_err = 0;
        m_ovf = 0;
        if (m_pending) begin
            if (w) m_ovf = 1;
            if (r) m_pending = 0;
        end else if (m_need == 0) begin
            if (w) begin
                len = int'(d[3:0]);
                if (d[31:24] != 8'hA5) begin
                    m_err = 1; m_code = 2'd1;
                end else if (len == 0 || len > int'(MAXW)) begin
                    m_err = 1; m_code = 2'd2;
                end else begin
                    m_opc  = d[23:20];
                    m_len  = d[3:0];
                    m_need = len;
                    m_idle = 0;
                    m_words.delete();
                end
            end
        end else begin
            if (w) begin
                m_words.push_back(d);
                m_idle = 0;
                if (m_words.size() == m_need) begin
                    m_pending = 1;
                    m_need    = 0;
                end
            end else begin
                m_idle++;
                if (TMO != 0 && m_idle == int'(TMO)) begin
                    m_err  = 1;
                    m_code = 2'd3;
                    m_need = 0;
                    m_words.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [PW-1:0] exp_pl;
        check_eq("cmd_valid", PW'(bus.cmd_valid), PW'(m_pending));
        check_eq("busy",      PW'(busy),          PW'(m_pending || m_need != 0));
        check_eq("err_pulse", PW'(err_pulse),     PW'(m_err));
        check_eq("err_code",  PW'(err_code),      PW'(m_code));
        check_eq("ovf_pulse", PW'(ovf_pulse),     PW'(m_ovf));
        if (m_pending) begin
            exp_pl = '0;
            foreach (m_words[k]) exp_pl[k*32 +: 32] = m_words[k];
            check_eq("cmd_opcode",  PW'(bus.cmd_opcode), PW'(m_opc));
            check_eq("cmd_len",     PW'(bus.cmd_len),    PW'(m_len));
            check_eq("cmd_payload", bus.cmd_payload,     exp_pl);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_valid",   PW'(bus.cmd_valid),  '0);
        check_eq("rst_busy",    PW'(busy),           '0);
        check_eq("rst_err",     PW'(err_pulse),      '0);
        check_eq("rst_code",    PW'(err_code),       '0);
        check_eq("rst_ovf",     PW'(ovf_pulse),      '0);
        check_eq("rst_opcode",  PW'(bus.cmd_opcode), '0);
        check_eq("rst_len",     PW'(bus.cmd_len),    '0);
        check_eq("rst_payload", bus.cmd_payload,     '0);
    endtask

    // Drive at the falling edge, let the rising edge sample, compare 1 time unit later.
    task automatic cycle(input logic w, input logic [31:0] d, input logic r);
        bus.write     = w;
        bus.writedata = d;
        bus.cmd_ready = r;
        @(posedge clk);
        model_step(w, d, r);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        int          pw;
        int          sel;
        logic [31:0] hdr;

        bus.write     = 1'b0;
        bus.writedata = '0;
        bus.cmd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Accepted two-word frame
        cycle(1'b1, 32'hA530_0002, 1'b1);
        cycle(1'b1, 32'h1111_1111, 1'b1);
        cycle(1'b1, 32'h2222_2222, 1'b1);
        check_eq("frame_opcode",  PW'(bus.cmd_opcode), PW'(4'd3));
        check_eq("frame_len",     PW'(bus.cmd_len),    PW'(4'd2));
        check_eq("frame_payload", bus.cmd_payload,     PW'(64'h2222_2222_1111_1111));
        idle(2);

        // Bad headers back-to-back
        cycle(1'b1, 32'h5A30_0001, 1'b1);
        cycle(1'b1, 32'hA530_0000, 1'b1);
        cycle(1'b1, 32'hA530_0009, 1'b1);
        check_eq("badlen_code", PW'(err_code), PW'(2'd2));
        idle(2);

        // Timeout after one of three words, then a normal frame
        cycle(1'b1, 32'hA510_0003, 1'b1);
        cycle(1'b1, 32'hCAFE_0001, 1'b1);
        idle(20);
        cycle(1'b1, 32'hA520_0001, 1'b1);
        cycle(1'b1, 32'h0BAD_F00D, 1'b1);
        idle(2);

        // Stall with two dropped writes, then handshake
        cycle(1'b1, 32'hA5F0_0002, 1'b0);
        cycle(1'b1, 32'h1234_5678, 1'b0);
        cycle(1'b1, 32'h9ABC_DEF0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5 || i == 10) cycle(1'b1, $urandom, 1'b0);
            else                   cycle(1'b0, 32'h0, 1'b0);
        end
        cycle(1'b0, 32'h0, 1'b1);
        idle(2);

        // Reset mid-frame
        cycle(1'b1, 32'hA560_0004, 1'b1);
        cycle(1'b1, 32'h5555_5555, 1'b1);
        bus.write = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'hA540_0001, 1'b1);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
        check_eq("post_rst_payload", bus.cmd_payload, PW'(32'hDEAD_BEEF));
        idle(2);

        // Header colliding with the handshake, then rewritten
        cycle(1'b1, 32'hA580_0001, 1'b1);
        cycle(1'b1, 32'h7777_7777, 1'b1);
        cycle(1'b1, 32'hA570_0001, 1'b1);
        cycle(1'b1, 32'hA570_0001, 1'b1);
        cycle(1'b1, 32'h8888_8888, 1'b1);
        idle(2);

        // Randomized traffic with varying write density
        for (int i = 0; i < 1500; i++) begin
            case ((i / 100) % 3)
                0:       pw = 90;
                1:       pw = 50;
                default: pw = 4;
            endcase
            if (!m_pending && m_need == 0) begin
                sel = int'($urandom_range(0, 9));
                hdr = $urandom;
                if (sel == 0) begin
                    hdr[31:24] = 8'(hdr[31:24] == 8'hA5 ? 8'h00 : hdr[31:24]);
                end else if (sel == 1) begin
                    hdr[31:24] = 8'hA5; hdr[3:0] = 4'd0;
                end else if (sel == 2) begin
                    hdr[31:24] = 8'hA5; hdr[3:0] = 4'($urandom_range(MAXW + 1, 15));
                end else begin
                    hdr[31:24] = 8'hA5; hdr[3:0] = 4'($urandom_range(1, MAXW));
                end
            end else begin
                hdr = $urandom;
            end
            cycle(($urandom_range(0, 99) < pw), hdr, ($urandom_range(0, 1) == 1));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
